// File: rtl/pc_fetch_redirect.sv
// IF-stage fetch unit: owns the PC, drives instruction memory over a single-outstanding
// req/ack handshake, applies ID-stage redirects/flushes and owns the IF/ID register.
// Optional build macro DELAY_SLOT_EN selects MIPS delay-slot semantics instead of squash.
module pc_fetch_redirect #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              is_branch,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              is_rst_IF_ID,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_plus4_ID,
    output logic [DATA_W-1:0] inst_ID,
    output logic              valid_ID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] hold_buf;

    logic              redir_c;
    logic [ADDR_W-1:0] target_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [ADDR_W-1:0] pc_after_c;
    logic [ADDR_W-1:0] pc_kill_c;
    logic              deliver_c;
    logic              flush_c;
    logic [DATA_W-1:0] deliver_data_c;

    // Redirect only counts when the hazard unit is not stalling; targets are word aligned.
    assign redir_c   = is_branch & ~stall;
    assign target_c  = branch_address & ~ADDR_W'(3);
    assign pc_inc_c  = pc + ADDR_W'(4);
    assign pc_kill_c = redir_c ? target_c : pc;

`ifdef DELAY_SLOT_EN
    logic              redir_pend;
    logic [ADDR_W-1:0] redir_addr;

    // The delay slot is never flushed, so the flush request has no effect here.
    assign flush_c = is_rst_IF_ID & 1'b0;

    // Delivery happens regardless of redirects; the redirect only steers the next PC.
    always_comb begin
        deliver_c      = 1'b0;
        deliver_data_c = imem_rdata;
        pc_after_c     = pc_inc_c;
        if (redir_pend) begin
            pc_after_c = redir_addr;
        end else if (redir_c) begin
            pc_after_c = target_c;
        end
        case (state)
            FETCH: deliver_c = imem_ack & ~stall;
            HOLD: begin
                deliver_c      = ~stall;
                deliver_data_c = hold_buf;
            end
            default: deliver_c = 1'b0;
        endcase
    end
`else
    assign flush_c    = is_rst_IF_ID;
    assign pc_after_c = pc_inc_c;

    // A redirect squashes whatever word is arriving or held.
    always_comb begin
        deliver_c      = 1'b0;
        deliver_data_c = imem_rdata;
        case (state)
            FETCH: deliver_c = imem_ack & ~stall & ~is_branch;
            HOLD: begin
                deliver_c      = ~stall & ~is_branch;
                deliver_data_c = hold_buf;
            end
            default: deliver_c = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            hold_buf    <= '0;
            pc_plus4_ID <= '0;
            inst_ID     <= '0;
            valid_ID    <= 1'b0;
`ifdef DELAY_SLOT_EN
            redir_pend  <= 1'b0;
            redir_addr  <= '0;
`endif
        end else begin
            // IF/ID: stall holds, flush beats load, otherwise load or bubble.
            if (!stall) begin
                if (flush_c || !deliver_c) begin
                    valid_ID <= 1'b0;
                    inst_ID  <= '0;
                end else begin
                    pc_plus4_ID <= pc_inc_c;
                    inst_ID     <= deliver_data_c;
                    valid_ID    <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (deliver_c) begin
                        pc        <= pc_after_c;
                        imem_addr <= pc_after_c;
`ifdef DELAY_SLOT_EN
                        redir_pend <= 1'b0;
`endif
                    end else if (imem_ack && stall) begin
                        hold_buf <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= HOLD;
`ifdef DELAY_SLOT_EN
                    end else if (redir_c && !redir_pend) begin
                        redir_pend <= 1'b1;
                        redir_addr <= target_c;
                    end
`else
                    end else if (redir_c) begin
                        pc <= target_c;
                        if (imem_ack) begin
                            imem_addr <= target_c;
                        end else begin
                            state <= KILL;
                        end
                    end
`endif
                end
                HOLD: begin
                    if (deliver_c) begin
                        pc        <= pc_after_c;
                        imem_addr <= pc_after_c;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
`ifdef DELAY_SLOT_EN
                        redir_pend <= 1'b0;
`endif
                    end else if (redir_c) begin
                        pc        <= target_c;
                        imem_addr <= target_c;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end
                end
                KILL: begin
                    // Stale request stays on the bus until memory answers; its data is dropped.
                    if (imem_ack) begin
                        pc        <= pc_kill_c;
                        imem_addr <= pc_kill_c;
                        state     <= FETCH;
                    end else if (redir_c) begin
                        pc <= target_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// Testbench for pc_fetch_redirect: directed scenarios followed by random stimulus,
// all checked against a word-fate reference model of the fetch stream.
module tb_pc_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        is_branch;
    logic [31:0] branch_address;
    logic        is_rst_IF_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;

    int checks = 0;
    int errors = 0;

    pc_fetch_redirect #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .is_branch     (is_branch),
        .branch_address(branch_address),
        .is_rst_IF_ID  (is_rst_IF_ID),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_plus4_ID   (pc_plus4_ID),
        .inst_ID       (inst_ID),
        .valid_ID      (valid_ID)
    );

    always #5 clk = ~clk;

    // Reference model: next fetch address, the fate of the outstanding/held word, expected outputs.
    logic [31:0] m_pc, m_hword, m_paddr;
    bit          m_started, m_held, m_stale, m_pend;
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_pc4, e_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          acc, got, avail, deliver, flush;
        logic [31:0] t, word, waddr;
        if (rst) begin
            m_pc = 32'h0; m_started = 0; m_held = 0; m_stale = 0; m_pend = 0;
            m_hword = 0; m_paddr = 0;
            e_req = 0; e_addr = 32'h0; e_pc4 = 0; e_inst = 0; e_valid = 0;
            return;
        end
        acc     = is_branch && !stall;
        t       = branch_address & 32'hFFFF_FFFC;
        got     = e_req && imem_ack;
        deliver = 0;
        waddr   = m_pc;
        word    = m_held ? m_hword : imem_rdata;
        if (!m_started) begin
            m_started = 1; e_req = 1; e_addr = m_pc;
        end else begin
            avail = m_held || (got && !m_stale);
            if (avail && stall) begin
                if (!m_held) begin
                    m_held = 1; m_hword = imem_rdata; e_req = 0;
                end
            end else if (avail) begin
`ifdef DELAY_SLOT_EN
                deliver = 1;
                m_pc = m_pend ? m_paddr : (acc ? t : m_pc + 32'd4);
                m_pend = 0;
`else
                deliver = !acc;
                m_pc = acc ? t : m_pc + 32'd4;
`endif
                m_held = 0; e_req = 1; e_addr = m_pc;
            end else begin
`ifdef DELAY_SLOT_EN
                if (acc && !m_pend) begin
                    m_pend = 1; m_paddr = t;
                end
`else
                if (acc) m_pc = t;
                if (got) begin
                    m_stale = 0; e_addr = m_pc;
                end else if (acc) begin
                    m_stale = 1;
                end
`endif
            end
        end
`ifdef DELAY_SLOT_EN
        flush = 0;
`else
        flush = is_rst_IF_ID;
`endif
        if (!stall) begin
            if (deliver && !flush) begin
                e_pc4 = waddr + 32'd4; e_inst = word; e_valid = 1;
            end else begin
                e_inst = 0; e_valid = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit b, input logic [31:0] ba,
                        input bit f, input bit a);
        @(negedge clk);
        rst = r; stall = s; is_branch = b; branch_address = ba;
        is_rst_IF_ID = f; imem_ack = a;
        imem_rdata = mem_word(imem_addr);
        model_step();
        @(posedge clk);
        #1;
        check("imem_req", 32'(imem_req), 32'(e_req));
        check("imem_addr", imem_addr, e_addr);
        check("valid_ID", 32'(valid_ID), 32'(e_valid));
        check("inst_ID", inst_ID, e_inst);
        check("pc_plus4_ID", pc_plus4_ID, e_pc4);
    endtask

    initial begin
        rst = 1; stall = 0; is_branch = 0; branch_address = 0;
        is_rst_IF_ID = 0; imem_ack = 0; imem_rdata = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_ID), 32'd0);

        // Back-to-back fetch from reset
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (i < 3) check("t1_addr", imem_addr, 32'(4 * i));
            if (i > 0) check("t1_pc4", pc_plus4_ID, 32'(4 * i));
        end

        // Stall on the ack cycle for 0xC, release after two cycles
        step(0, 1, 0, 0, 0, 1);
        check("t2_hold_req", 32'(imem_req), 32'd0);
        check("t2_frozen_pc4", pc_plus4_ID, 32'h0000_000C);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check("t2_inst", inst_ID, mem_word(32'h0000_000C));
        check("t2_next_addr", imem_addr, 32'h0000_0010);

`ifdef DELAY_SLOT_EN
        // Delay slot at 0x10 delivered despite flush request; fetch continues at target
        step(0, 0, 1, 32'h0000_0100, 1, 1);
        check("t5_valid", 32'(valid_ID), 32'd1);
        check("t5_inst", inst_ID, mem_word(32'h0000_0010));
        check("t5_addr", imem_addr, 32'h0000_0100);
`else
        // Redirect in the ack cycle drops the arriving word
        step(0, 0, 1, 32'h0000_0100, 0, 1);
        check("t3_valid", 32'(valid_ID), 32'd0);
        check("t3_addr", imem_addr, 32'h0000_0100);
        // Redirect with delayed ack: stale request held, then target fetched
        step(0, 0, 1, 32'h0000_0203, 0, 0);
        check("t4_stale_addr", imem_addr, 32'h0000_0100);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t4_stale_req", 32'(imem_req), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("t4_valid", 32'(valid_ID), 32'd0);
        check("t4_new_addr", imem_addr, 32'h0000_0200);
`endif

        // Reset while a word is held
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_valid", 32'(valid_ID), 32'd0);
        check("t6_addr", imem_addr, 32'h0000_0000);
        step(0, 0, 0, 0, 0, 0);
        check("t6_resume", 32'(imem_req), 32'd1);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1);
        check("wrap_pc4", pc_plus4_ID, 32'h0000_0000);
        check("wrap_next", imem_addr, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), ba,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
